// File: rtl/shift_chain_pkg.sv
// Shared types and defaults for the shift-chain receiver.
package shift_chain_pkg;

    localparam int SYNC_STAGES  = 2;
    localparam int DEF_LANES    = 16;
    localparam int DEF_DEPTH    = 8;
    localparam int DEF_TIMEOUT  = 1024;
    localparam int DEF_PERIOD_W = 24;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        SHIFTING = 1'b1
    } state_e;

endpackage

// File: rtl/shift_chain_edge_sync.sv
// edge_sync: multi-stage synchroniser for one asynchronous pin plus rising-edge detect.
module edge_sync
    import shift_chain_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // NOTE: sequential state uses non-blocking assignments so every stage samples the pre-edge value.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_async};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign o_rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/shift_chain_receiver.sv
// shift_chain_receiver: oversamples a serial shift-register bus and deserialises each lane into a frame.
// Define SHIFT_CHAIN_STATS_EN to add o_frame_count / o_err_count statistics ports.
module shift_chain_receiver
    import shift_chain_pkg::*;
#(
    parameter int LANES    = DEF_LANES,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int TIMEOUT  = DEF_TIMEOUT,
    parameter int PERIOD_W = DEF_PERIOD_W
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [LANES-1:0]       i_channel,
    input  logic                   i_data_clk,
    input  logic                   i_latch,
    input  logic                   i_sync,
    output logic [LANES*DEPTH-1:0] o_frame,
    output logic                   o_valid,
    output logic                   o_frame_err,
    output logic                   o_sync_pulse,
`ifdef SHIFT_CHAIN_STATS_EN
    output logic [31:0]            o_frame_count,
    output logic [15:0]            o_err_count,
`endif
    output logic [PERIOD_W-1:0]    o_sync_period
);

    localparam int                CNT_W     = $clog2(2 * DEPTH + 1);
    localparam int                IDLE_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(2 * DEPTH);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    logic shift_ev, latch_ev, sync_ev, timeout_ev;

    logic [SYNC_STAGES*LANES-1:0] lane_chain_q;
    logic [LANES-1:0]             lane_bits;

    state_e                   state_q, state_d;
    logic [LANES*DEPTH-1:0]   shreg_q, shreg_d;
    logic [LANES*DEPTH-1:0]   frame_q, frame_d;
    logic [CNT_W-1:0]         bit_cnt_q, bit_cnt_d;
    logic [IDLE_W-1:0]        idle_cnt_q, idle_cnt_d;
    logic                     valid_q, valid_d;
    logic                     frame_err_q, frame_err_d;
    logic [PERIOD_W-1:0]      period_cnt_q, period_cnt_d;
    logic [PERIOD_W-1:0]      sync_period_q, sync_period_d;
    logic                     sync_pulse_q, sync_pulse_d;

    edge_sync u_data_clk_sync (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_async(i_data_clk), .o_rise(shift_ev));
    edge_sync u_latch_sync    (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_async(i_latch),    .o_rise(latch_ev));
    edge_sync u_sync_sync     (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_async(i_sync),     .o_rise(sync_ev));

    // Lanes see the same number of stages as the edge detectors, so lane_bits is the value present at the shift edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) lane_chain_q <= '0;
        else          lane_chain_q <= {lane_chain_q[(SYNC_STAGES-1)*LANES-1:0], i_channel};
    end

    assign lane_bits  = lane_chain_q[SYNC_STAGES*LANES-1 -: LANES];
    assign timeout_ev = (state_q == SHIFTING) && !shift_ev && !latch_ev && (idle_cnt_q == IDLE_LAST);

    // NOTE: every always_comb output is assigned a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        frame_d     = frame_q;
        bit_cnt_d   = bit_cnt_q;
        idle_cnt_d  = idle_cnt_q;
        valid_d     = 1'b0;
        frame_err_d = frame_err_q;

        if (shift_ev) begin
            for (int n = 0; n < LANES; n++) begin
                shreg_d[n*DEPTH +: DEPTH] = {shreg_q[n*DEPTH +: DEPTH-1], lane_bits[n]};
            end
            if (bit_cnt_q != CNT_MAX) bit_cnt_d = bit_cnt_q + 1'b1;
            idle_cnt_d = '0;
            state_d    = SHIFTING;
        end else if (state_q == SHIFTING) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
        end

        // A coincident shift has already been folded into shreg_d / bit_cnt_d.
        if (latch_ev) begin
            frame_d     = shreg_d;
            valid_d     = 1'b1;
            frame_err_d = (bit_cnt_d != CNT_FULL);
            bit_cnt_d   = '0;
            idle_cnt_d  = '0;
            state_d     = IDLE;
        end else if (timeout_ev) begin
            frame_err_d = 1'b1;
            bit_cnt_d   = '0;
            idle_cnt_d  = '0;
            state_d     = IDLE;
        end
    end

    always_comb begin
        period_cnt_d  = (&period_cnt_q) ? period_cnt_q : period_cnt_q + 1'b1;
        sync_period_d = sync_period_q;
        sync_pulse_d  = sync_ev;
        if (sync_ev) begin
            sync_period_d = period_cnt_q;
            period_cnt_d  = PERIOD_W'(1);
        end
    end

    // NOTE: the lane shift registers are reset too, so a frame latched before any shift reads as zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= IDLE;
            shreg_q       <= '0;
            frame_q       <= '0;
            bit_cnt_q     <= '0;
            idle_cnt_q    <= '0;
            valid_q       <= 1'b0;
            frame_err_q   <= 1'b0;
            period_cnt_q  <= '0;
            sync_period_q <= '0;
            sync_pulse_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            frame_q       <= frame_d;
            bit_cnt_q     <= bit_cnt_d;
            idle_cnt_q    <= idle_cnt_d;
            valid_q       <= valid_d;
            frame_err_q   <= frame_err_d;
            period_cnt_q  <= period_cnt_d;
            sync_period_q <= sync_period_d;
            sync_pulse_q  <= sync_pulse_d;
        end
    end

    assign o_frame       = frame_q;
    assign o_valid       = valid_q;
    assign o_frame_err   = frame_err_q;
    assign o_sync_pulse  = sync_pulse_q;
    assign o_sync_period = sync_period_q;

`ifdef SHIFT_CHAIN_STATS_EN
    logic [31:0] frame_count_q, frame_count_d;
    logic [15:0] err_count_q, err_count_d;

    always_comb begin
        frame_count_d = frame_count_q;
        err_count_d   = err_count_q;
        if (latch_ev && !frame_err_d)              frame_count_d = frame_count_q + 32'd1;
        if ((latch_ev && frame_err_d) || timeout_ev) err_count_d = err_count_q + 16'd1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            frame_count_q <= '0;
            err_count_q   <= '0;
        end else begin
            frame_count_q <= frame_count_d;
            err_count_q   <= err_count_d;
        end
    end

    assign o_frame_count = frame_count_q;
    assign o_err_count   = err_count_q;
`endif

endmodule

// File: tb/tb_shift_chain_receiver.sv
// Randomised self-checking bench for shift_chain_receiver against a queue-based frame model.
module tb_shift_chain_receiver;

    localparam int LANES    = 16;
    localparam int DEPTH    = 8;
    localparam int PERIOD_W = 24;

    logic                   i_clk = 1'b0;
    logic                   i_rst_n = 1'b0;
    logic [LANES-1:0]       i_channel = '0;
    logic                   i_data_clk = 1'b0;
    logic                   i_latch = 1'b0;
    logic                   i_sync = 1'b0;
    logic [LANES*DEPTH-1:0] o_frame;
    logic                   o_valid;
    logic                   o_frame_err;
    logic                   o_sync_pulse;
    logic [PERIOD_W-1:0]    o_sync_period;
`ifdef SHIFT_CHAIN_STATS_EN
    logic [31:0]            o_frame_count;
    logic [15:0]            o_err_count;
`endif

    shift_chain_receiver dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_channel     (i_channel),
        .i_data_clk    (i_data_clk),
        .i_latch       (i_latch),
        .i_sync        (i_sync),
        .o_frame       (o_frame),
        .o_valid       (o_valid),
        .o_frame_err   (o_frame_err),
        .o_sync_pulse  (o_sync_pulse),
`ifdef SHIFT_CHAIN_STATS_EN
        .o_frame_count (o_frame_count),
        .o_err_count   (o_err_count),
`endif
        .o_sync_period (o_sync_period)
    );

    always #10 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int valid_cnt = 0;
    int last_valid_cyc = 0;
    always @(posedge i_clk) begin
        #2;
        if (o_valid) begin
            valid_cnt      <= valid_cnt + 1;
            last_valid_cyc <= cyc;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: every word ever shifted since reset, bits since the last frame boundary.
    logic [LANES-1:0]       hist[$];
    int                     mdl_bits = 0;
    logic [LANES*DEPTH-1:0] mdl_frame = '0;
    int                     exp_good = 0;
    int                     exp_err  = 0;

    function automatic logic [LANES*DEPTH-1:0] expect_frame();
        logic [LANES*DEPTH-1:0] f;
        f = '0;
        for (int k = 0; k < DEPTH; k++) begin
            int idx;
            idx = hist.size() - DEPTH + k;
            if (idx >= 0)
                for (int n = 0; n < LANES; n++) f[n*DEPTH + DEPTH-1-k] = hist[idx][n];
        end
        return f;
    endfunction

    task automatic model_shift(input logic [LANES-1:0] w);
        hist.push_back(w);
        if (mdl_bits < 2*DEPTH) mdl_bits++;
    endtask

    task automatic shift_bit(input logic [LANES-1:0] w);
        @(negedge i_clk);
        i_channel = w;
        repeat (2) @(negedge i_clk);
        i_data_clk = 1'b1;
        repeat (3) @(negedge i_clk);
        i_data_clk = 1'b0;
        repeat (2) @(negedge i_clk);
        model_shift(w);
    endtask

    task automatic do_latch(input string tag, input bit with_shift, input logic [LANES-1:0] w);
        int  v0, c0;
        logic err;
        @(negedge i_clk);
        if (with_shift) begin
            i_channel = w;
            repeat (2) @(negedge i_clk);
            i_data_clk = 1'b1;
            model_shift(w);
        end
        v0 = valid_cnt;
        c0 = cyc;
        i_latch = 1'b1;
        repeat (6) @(negedge i_clk);
        i_latch    = 1'b0;
        i_data_clk = 1'b0;
        repeat (2) @(negedge i_clk);
        mdl_frame = expect_frame();
        err       = (mdl_bits != DEPTH);
        mdl_bits  = 0;
        if (err) exp_err++;
        else     exp_good++;
        check({tag, ".valid_count"}, 128'(valid_cnt - v0), 128'd1);
        check({tag, ".valid_latency"}, 128'(last_valid_cyc - c0), 128'd3);
        check({tag, ".frame"}, o_frame, mdl_frame);
        check({tag, ".frame_err"}, 128'(o_frame_err), 128'(err));
`ifdef SHIFT_CHAIN_STATS_EN
        check({tag, ".frame_count"}, 128'(o_frame_count), 128'(exp_good));
        check({tag, ".err_count"}, 128'(o_err_count), 128'(exp_err));
`endif
    endtask

    task automatic send_frame(input string tag, input int nbits, input bit with_shift);
        for (int i = 0; i < nbits; i++) shift_bit(LANES'($urandom));
        do_latch(tag, with_shift, LANES'($urandom));
    endtask

    task automatic sync_rise(input string tag);
        i_sync = 1'b1;
        repeat (3) @(negedge i_clk);
        check({tag, ".pulse"}, 128'(o_sync_pulse), 128'd1);
        @(negedge i_clk);
        check({tag, ".pulse_end"}, 128'(o_sync_pulse), 128'd0);
        i_sync = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".frame"}, o_frame, 128'd0);
        check({tag, ".valid"}, 128'(o_valid), 128'd0);
        check({tag, ".frame_err"}, 128'(o_frame_err), 128'd0);
        check({tag, ".sync_pulse"}, 128'(o_sync_pulse), 128'd0);
        check({tag, ".sync_period"}, 128'(o_sync_period), 128'd0);
`ifdef SHIFT_CHAIN_STATS_EN
        check({tag, ".frame_count"}, 128'(o_frame_count), 128'd0);
        check({tag, ".err_count"}, 128'(o_err_count), 128'd0);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] a5, c3;
        int v0, c0, nb;

        repeat (3) @(negedge i_clk);
        check_reset_outputs("reset");
        i_rst_n = 1'b1;
        repeat (3) @(negedge i_clk);

        // Known pattern on lane 0 and lane 15.
        a5 = 8'hA5;
        c3 = 8'h3C;
        for (int k = 0; k < DEPTH; k++) begin
            logic [LANES-1:0] w;
            w     = '0;
            w[0]  = a5[DEPTH-1-k];
            w[15] = c3[DEPTH-1-k];
            shift_bit(w);
        end
        do_latch("pattern", 1'b0, '0);
        check("pattern.lane0", 128'(o_frame[7:0]), 128'hA5);
        check("pattern.lane15", 128'(o_frame[127:120]), 128'h3C);

        send_frame("short7", 7, 1'b0);
        send_frame("recover8", 8, 1'b0);
        send_frame("coincident8", 7, 1'b1);

        for (int i = 0; i < 8; i++) begin
            nb = ($urandom_range(0, 1) == 1) ? 8 : int'($urandom_range(0, 10));
            send_frame("random", nb, 1'b0);
        end
        send_frame("pre_timeout", 8, 1'b0);

        // Partial frame abandoned by the idle timeout.
        for (int i = 0; i < 3; i++) shift_bit(LANES'($urandom));
        v0 = valid_cnt;
        repeat (990) @(negedge i_clk);
        check("timeout.early_err", 128'(o_frame_err), 128'd0);
        repeat (60) @(negedge i_clk);
        check("timeout.err", 128'(o_frame_err), 128'd1);
        check("timeout.no_valid", 128'(valid_cnt - v0), 128'd0);
        check("timeout.frame_kept", o_frame, mdl_frame);
        mdl_bits = 0;
        exp_err++;
`ifdef SHIFT_CHAIN_STATS_EN
        check("timeout.err_count", 128'(o_err_count), 128'(exp_err));
`endif
        send_frame("after_timeout", 8, 1'b0);

        // Sync pulses 1000 cycles apart with a frame in between.
        @(negedge i_clk);
        c0 = cyc;
        sync_rise("sync1");
        send_frame("during_sync", 8, 1'b0);
        while (cyc < c0 + 1000) @(negedge i_clk);
        sync_rise("sync2");
        check("sync2.period", 128'(o_sync_period), 128'd1000);

        // Reset in the middle of a frame.
        for (int i = 0; i < 4; i++) shift_bit(LANES'($urandom));
        @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        hist.delete();
        mdl_bits  = 0;
        exp_good  = 0;
        exp_err   = 0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);
        send_frame("post_reset", 8, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
